// File: rtl/ofifo_drain_ctrl.sv
// Output-FIFO drain controller: pops len rows into psum SRAM starting at base_addr.
// Optional build macro RELU_EN clamps negative lanes to zero in the write-data register.
module ofifo_drain_ctrl #(
  parameter int col    = 8,
  parameter int bw     = 16,
  parameter int addr_w = 11,
  parameter int len_w  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [len_w-1:0]      len,
  input  logic [addr_w-1:0]     base_addr,
  input  logic [col*bw-1:0]     fifo_out,
  input  logic                  fifo_valid,
  output logic                  fifo_rd,
  input  logic                  mem_ready,
  output logic                  mem_wen,
  output logic [addr_w-1:0]     mem_addr,
  output logic [col*bw-1:0]     mem_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [len_w-1:0]  len_zero = {len_w{1'b0}};
  localparam logic [len_w-1:0]  len_one  = {{(len_w-1){1'b0}}, 1'b1};
  localparam logic [addr_w-1:0] addr_one = {{(addr_w-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              next_state_s;
  logic [len_w-1:0]    cnt_r;
  logic [len_w-1:0]    len_r;
  logic [addr_w-1:0]   addr_r;
  logic                pop_s;
  logic                mem_wen_r;
  logic [addr_w-1:0]   mem_addr_r;
  logic [col*bw-1:0]   mem_data_r;
  logic                busy_r;
  logic                done_r;

  function automatic logic [col*bw-1:0] shape_row(input logic [col*bw-1:0] row);
    logic [col*bw-1:0] res;
    res = row;
`ifdef RELU_EN
    for (int i = 0; i < col; i++) begin
      if (row[i*bw + bw - 1]) begin
        res[i*bw +: bw] = {bw{1'b0}};
      end else begin
        res[i*bw +: bw] = row[i*bw +: bw];
      end
    end
`endif
    return res;
  endfunction

  // Next-state decode and pop qualification; reset suppresses the pop in the same cycle.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len == len_zero) begin
            next_state_s = DONE;
          end else begin
            next_state_s = DRAIN;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      DRAIN: begin
        pop_s = fifo_valid & mem_ready & (cnt_r < len_r) & ~reset;
        if (pop_s && (cnt_r == (len_r - len_one))) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, drain counters and the registered SRAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= len_zero;
      len_r      <= len_zero;
      addr_r     <= {addr_w{1'b0}};
      mem_wen_r  <= 1'b0;
      mem_addr_r <= {addr_w{1'b0}};
      mem_data_r <= {(col*bw){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      busy_r    <= (next_state_s != IDLE);
      done_r    <= (next_state_s == DONE);
      mem_wen_r <= pop_s;
      if ((state_r == IDLE) && start) begin
        len_r  <= len;
        addr_r <= base_addr;
        cnt_r  <= len_zero;
      end else if (pop_s) begin
        mem_addr_r <= addr_r;
        mem_data_r <= shape_row(fifo_out);
        addr_r     <= addr_r + addr_one;
        cnt_r      <= cnt_r + len_one;
      end else begin
        cnt_r  <= cnt_r;
        addr_r <= addr_r;
      end
    end
  end

  assign fifo_rd  = pop_s;
  assign mem_wen  = mem_wen_r;
  assign mem_addr = mem_addr_r;
  assign mem_data = mem_data_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Scoreboard bench for ofifo_drain_ctrl: a queue-based FIFO model feeds rows, expected writes are
// queued when rows are loaded and compared when mem_wen appears.
module tb_ofifo_drain_ctrl;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int AW  = 11;
  localparam int LW  = 11;
  localparam int DW  = COL * BW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset, start, fifo_valid, fifo_rd, mem_ready, mem_wen, busy, done;
  logic [LW-1:0] len;
  logic [AW-1:0] base_addr, mem_addr, exp_done_addr;
  logic [DW-1:0] fifo_out, mem_data;
  logic          valid_gate, last_rd, exp_done_wen;
  logic [DW-1:0] fifo_q[$];
  wr_t           exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            pops, done_hits, cyc;

  ofifo_drain_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
    .fifo_out(fifo_out), .fifo_valid(fifo_valid), .fifo_rd(fifo_rd),
    .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_row(input logic [DW-1:0] r);
    logic [DW-1:0] o;
    o = r;
`ifdef RELU_EN
    for (int i = 0; i < COL; i++) begin
      if ($signed(r[i*BW +: BW]) < 0) o[i*BW +: BW] = {BW{1'b0}};
    end
`endif
    return o;
  endfunction

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_valid = valid_gate && (fifo_q.size() > 0);
    fifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : {DW{1'b0}};
  endtask

  task automatic tick();
    wr_t e;
    drive_fifo();
    #1;
    last_rd = fifo_rd;
    if (last_rd) check_val("rd_in_done", DW'(done), DW'(1'b0));
    @(posedge clk);
    if (last_rd && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    #1;
    if (mem_wen) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", DW'(mem_wen), DW'(1'b0));
      end else begin
        e = exp_q.pop_front();
        check_val("wr_addr", DW'(mem_addr), DW'(e.addr));
        check_val("wr_data", mem_data, e.data);
      end
    end
    if (done) begin
      done_hits++;
      check_val("done_wen", DW'(mem_wen), DW'(exp_done_wen));
      if (exp_done_wen) check_val("done_addr", DW'(mem_addr), DW'(exp_done_addr));
      check_val("done_all_written", DW'(exp_q.size()), DW'(0));
    end
  endtask

  task automatic load(input int n, input int nexp, input logic [AW-1:0] base);
    logic [DW-1:0] row;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      row = {$urandom, $urandom, $urandom, $urandom};
      fifo_q.push_back(row);
      if (i < nexp) begin
        e.addr = base + AW'(i);
        e.data = ref_row(row);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_drain(input logic [LW-1:0] l, input logic [AW-1:0] b);
    start = 1'b1; len = l; base_addr = b;
    done_hits = 0; pops = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    cyc = 0;
    while (done_hits == 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    check_val("done_seen", DW'(done_hits > 0), DW'(1'b1));
  endtask

  initial begin
    logic [DW-1:0] row;
    wr_t e;
    logic [4:0] pat;
    reset = 1'b1; start = 1'b0; len = '0; base_addr = '0;
    valid_gate = 1'b1; mem_ready = 1'b1; exp_done_wen = 1'b1; exp_done_addr = '0;
    pops = 0; done_hits = 0;
    tick(); tick();
    check_val("rst_wen", DW'(mem_wen), DW'(1'b0));
    check_val("rst_addr", DW'(mem_addr), DW'(0));
    check_val("rst_data", mem_data, {DW{1'b0}});
    check_val("rst_busy", DW'(busy), DW'(1'b0));
    check_val("rst_done", DW'(done), DW'(1'b0));
    reset = 1'b0;
    tick();

    // 1: four back-to-back rows from 0x010; first row carries the ReLU probe lanes
    row = {$urandom, $urandom, $urandom, $urandom};
    row[15:0] = 16'hFFF6; row[31:16] = 16'h0005;
    fifo_q.push_back(row);
    e.addr = 11'h010; e.data = ref_row(row); exp_q.push_back(e);
`ifdef RELU_EN
    check_val("relu_neg_lane", DW'(e.data[15:0]), DW'(16'h0000));
`else
    check_val("pass_neg_lane", DW'(e.data[15:0]), DW'(16'hFFF6));
`endif
    check_val("pos_lane", DW'(e.data[31:16]), DW'(16'h0005));
    load(3, 3, 11'h011);
    exp_done_addr = 11'h013;
    start_drain(11'd4, 11'h010);
    check_val("t1_busy", DW'(busy), DW'(1'b1));
    wait_done(20);
    check_val("t1_latency", DW'(cyc), DW'(4));
    check_val("t1_pops", DW'(pops), DW'(4));
    tick();
    check_val("t1_idle", DW'(busy), DW'(1'b0));

    // 2: fifo_valid toggling 1,0,1,0,1
    load(3, 3, 11'h020);
    exp_done_addr = 11'h022;
    start_drain(11'd3, 11'h020);
    pat = 5'b10101;
    for (int k = 0; k < 5; k++) begin
      valid_gate = pat[k];
      tick();
    end
    valid_gate = 1'b1;
    check_val("t2_done", DW'(done_hits), DW'(1));
    check_val("t2_pops", DW'(pops), DW'(3));
    tick();

    // 3: mem_ready low for five cycles after two pops
    load(6, 6, 11'h040);
    exp_done_addr = 11'h045;
    start_drain(11'd6, 11'h040);
    tick(); tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("t3_stall_rd", DW'(last_rd), DW'(1'b0));
      check_val("t3_stall_wen", DW'(mem_wen), DW'(1'b0));
      check_val("t3_stall_addr", DW'(mem_addr), DW'(11'h041));
    end
    check_val("t3_stall_pops", DW'(pops), DW'(2));
    mem_ready = 1'b1;
    wait_done(20);
    check_val("t3_pops", DW'(pops), DW'(6));
    tick();

    // 4: address wrap at the top of the SRAM
    load(2, 2, 11'h7FF);
    exp_done_addr = 11'h000;
    start_drain(11'd2, 11'h7FF);
    wait_done(10);
    tick();

    // 5a: zero-length drain
    load(1, 0, 11'h000);
    exp_done_wen = 1'b0;
    start_drain(11'd0, 11'h055);
    check_val("t5_done_next", DW'(done_hits), DW'(1));
    check_val("t5_pops", DW'(pops), DW'(0));
    tick();
    check_val("t5_idle", DW'(busy), DW'(1'b0));
    check_val("t5_fifo_left", DW'(fifo_q.size()), DW'(1));
    fifo_q.delete();

    // 5b: start while busy is ignored
    load(5, 3, 11'h100);
    exp_done_wen = 1'b1; exp_done_addr = 11'h102;
    start_drain(11'd3, 11'h100);
    start = 1'b1; len = 11'd5; base_addr = 11'h200;
    tick();
    start = 1'b0;
    wait_done(10);
    check_val("t5_busy_pops", DW'(pops), DW'(3));
    check_val("t5_busy_left", DW'(fifo_q.size()), DW'(2));
    tick();
    fifo_q.delete();

    // 6: reset after the second pop of a six-row drain
    load(6, 2, 11'h300);
    start_drain(11'd6, 11'h300);
    tick(); tick();
    reset = 1'b1;
    tick();
    check_val("t6_rd_gated", DW'(last_rd), DW'(1'b0));
    check_val("t6_fifo_left", DW'(fifo_q.size()), DW'(4));
    check_val("t6_wen", DW'(mem_wen), DW'(1'b0));
    check_val("t6_addr", DW'(mem_addr), DW'(0));
    check_val("t6_data", mem_data, {DW{1'b0}});
    check_val("t6_busy", DW'(busy), DW'(1'b0));
    check_val("t6_done", DW'(done), DW'(1'b0));
    reset = 1'b0;
    fifo_q.delete();
    tick();
    check_val("t6_no_rd_after", DW'(last_rd), DW'(1'b0));

    check_val("sb_empty", DW'(exp_q.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
